// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter with branch/jump/call/ret and a return stack.
//               Stack faults are trapped to TRAP_VEC and flagged stickily.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                ADDR_W      = 19,
  parameter int                STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(19'h7FF00)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [ADDR_W-1:0]              target,
  input  logic                           clr_err,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic [ADDR_W-1:0]              stack_top,
  output logic                           ovf,
  output logic                           unf
);

  localparam int c_idx_w = $clog2(STACK_DEPTH);
  localparam int c_dep_w = c_idx_w + 1;
  localparam logic [c_dep_w-1:0] c_full = c_dep_w'(STACK_DEPTH);

  logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_stack_top;
  logic [c_dep_w-1:0] r_depth;
  logic               r_ovf;
  logic               r_unf;

  logic [ADDR_W-1:0]  w_pc_inc;
  logic [c_idx_w-1:0] w_push_idx;
  logic [c_idx_w-1:0] w_top_idx;
  logic [c_idx_w-1:0] w_below_idx;
  logic [ADDR_W-1:0]  w_below_top;
  logic               w_full;
  logic               w_empty;

  assign w_pc_inc    = r_pc + 1'b1;
  assign w_full      = (r_depth == c_full);
  assign w_empty     = (r_depth == '0);
  assign w_push_idx  = r_depth[c_idx_w-1:0];
  // Adding all-ones subtracts one modulo the index width, for any width.
  assign w_top_idx   = r_depth[c_idx_w-1:0] + {c_idx_w{1'b1}};
  assign w_below_idx = w_top_idx + {c_idx_w{1'b1}};
  // Entry that becomes the new top after a pop; zero when the pop empties the stack.
  assign w_below_top = (r_depth > c_dep_w'(1)) ? r_stack[w_below_idx] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc        <= RESET_VEC;
      r_depth     <= '0;
      r_stack_top <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      // Clear first so that a fault later in this block wins.
      if (clr_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (!stall) begin
        if (ret) begin
          if (w_empty) begin
            r_unf <= 1'b1;
            r_pc  <= TRAP_VEC;
          end else begin
            r_pc        <= r_stack_top;
            r_depth     <= r_depth - 1'b1;
            r_stack_top <= w_below_top;
          end
        end else if (call) begin
          if (w_full) begin
            r_ovf <= 1'b1;
            r_pc  <= TRAP_VEC;
          end else begin
            r_stack[w_push_idx] <= w_pc_inc;
            r_stack_top         <= w_pc_inc;
            r_depth             <= r_depth + 1'b1;
            r_pc                <= target;
          end
        end else if (branch || jump) begin
          r_pc <= target;
        end else begin
          r_pc <= w_pc_inc;
        end
      end
    end
  end

  assign pc        = r_pc;
  assign depth     = r_depth;
  assign stack_top = r_stack_top;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, program-counter and address width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 16, return-stack entries; power of two, 2..64.
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 SHALL have parameter TRAP_VEC, default 19'h7FF00, PC value loaded on stack fault.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset, sampled on clk rising edge.
REQ-007 SHALL have port stall, input, 1, hold PC and stack unchanged this cycle.
REQ-008 SHALL have port branch, input, 1, conditional branch taken; load target.
REQ-009 SHALL have port jump, input, 1, unconditional jump; load target.
REQ-010 SHALL have port call, input, 1, push return address and load target.
REQ-011 SHALL have port ret, input, 1, pop return address into PC.
REQ-012 SHALL have port target, input, ADDR_W, destination for branch/jump/call.
REQ-013 SHALL have port clr_err, input, 1, clear sticky fault flags.
REQ-014 SHALL have port pc, output, ADDR_W, current program counter (registered).
REQ-015 SHALL have port depth, output, clog2(STACK_DEPTH)+1, number of valid stack entries.
REQ-016 SHALL have port stack_top, output, ADDR_W, entry a ret would pop; 0 when depth==0.
REQ-017 SHALL have port ovf, output, 1, sticky: call attempted with stack full.
REQ-018 SHALL have port unf, output, 1, sticky: ret attempted with stack empty.

Function
REQ-019 SHALL evaluate one action per cycle with priority: reset > stall > ret > call > branch|jump > increment.
REQ-020 SHALL, on increment, set pc <= pc+1 modulo 2^ADDR_W (all-ones wraps to 0, no flag).
REQ-021 SHALL, on branch or jump, set pc <= target; stack and depth unchanged.
REQ-022 SHALL, on call with depth<STACK_DEPTH, write pc+1 (mod 2^ADDR_W) to the stack, increment depth, set pc <= target, in the same cycle.
REQ-023 SHALL, on ret with depth>0, set pc <= stack_top and decrement depth, in the same cycle.
REQ-024 SHALL, on call with depth==STACK_DEPTH, suppress the push, keep depth, set ovf, set pc <= TRAP_VEC.
REQ-025 SHALL, on ret with depth==0, keep depth 0, set unf, set pc <= TRAP_VEC.
REQ-026 SHALL treat call and ret asserted together as ret only; the call is discarded without fault.
REQ-027 SHALL, under stall, ignore all control inputs except reset and clr_err; pc, depth and stack are held.
REQ-028 SHALL clear ovf and unf on clr_err; a fault in the same cycle as clr_err SHALL leave its flag set (set wins).
REQ-029 SHALL update all outputs one cycle after the sampling edge; no combinational path from inputs to outputs.
REQ-030 SHALL present stack_top as registered stack content at index depth-1, updated in the same cycle as depth.
REQ-031 SHALL support nesting exactly STACK_DEPTH deep; returns yield addresses in LIFO order.

Reset
REQ-032 SHALL, when reset is low at a rising clk edge, set pc=RESET_VEC, depth=0, ovf=0, unf=0, stack_top=0, overriding all other inputs.
REQ-033 SHALL discard stack contents on reset; no entry is retrievable afterwards.
REQ-034 SHALL respond to reset low mid-call or mid-stall identically to REQ-032 with no partial update.
REQ-035 SHALL leave outputs undefined-free: every register has a reset value.

Verification
REQ-036 SHALL cover: reset low 1 cycle, then 3 idle cycles -> pc 0,1,2,3; depth 0.
REQ-037 SHALL cover: pc=0x10, call target=0x200; then ret -> pc 0x200, depth 1, stack_top 0x11; then pc 0x11, depth 0.
REQ-038 SHALL cover: 16 nested calls then 17th call -> depth 16, ovf=1, pc=TRAP_VEC; 16 rets return addresses in reverse order.
REQ-039 SHALL cover: ret at depth 0 -> unf=1, pc=TRAP_VEC; clr_err next cycle -> unf=0.
REQ-040 SHALL cover: call+ret same cycle at depth 2 -> depth 1, pc=popped address, ovf=unf=0; stall with jump asserted -> pc unchanged.
REQ-041 SHALL cover: pc=0x7FFFF idle -> pc 0; reset low during call -> pc=0, depth 0.
